// File: rtl/acc_exec_unit.sv
// acc_exec_unit: execute-stage sequencer for the accumulator processor.
// It drives the external 8-bit ALU from ACC and the operand, then writes the
// ALU sum and flags back. It also runs an 8x8 unsigned shift-add multiply using
// the same ALU, and offers a valid/ready handshake to the decode stage.
// Ports:
//   clk_in, rst_n_in                  clock, async active-low reset
//   op_valid_in / op_ready_out        op handshake with decode
//   opcode_in[3:0], operand_in[7:0]   op and operand, latched on accept
//   alu_a_out, alu_b_out, alu_ctrl_out  registered ALU drive
//   alu_sum_in, alu_carry_in, alu_overflow_in, alu_zero_in  ALU results
//   acc_out, ph_out                   accumulator and product-high register
//   carry_flag_out, overflow_flag_out, zero_flag_out  C/V/Z flags
//   done_out                          one-cycle pulse when writeback is visible
module acc_exec_unit #(
    parameter logic [2:0]  ALU_ADD  = 3'b010,
    parameter int unsigned MUL_ITER = 8
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       op_valid_in,
    output logic       op_ready_out,
    input  logic [3:0] opcode_in,
    input  logic [7:0] operand_in,
    output logic [7:0] alu_a_out,
    output logic [7:0] alu_b_out,
    output logic [2:0] alu_ctrl_out,
    input  logic [7:0] alu_sum_in,
    input  logic       alu_carry_in,
    input  logic       alu_overflow_in,
    input  logic       alu_zero_in,
    output logic [7:0] acc_out,
    output logic [7:0] ph_out,
    output logic       carry_flag_out,
    output logic       overflow_flag_out,
    output logic       zero_flag_out,
    output logic       done_out
);

    localparam int unsigned DW    = 8;
    localparam int unsigned OPW   = 4;
    localparam int unsigned CW    = 3;
    localparam int unsigned CNT_W = 4;

    localparam logic [OPW-1:0] OP_LDA  = 4'b1000;
    localparam logic [OPW-1:0] OP_CLR  = 4'b1001;
    localparam logic [OPW-1:0] OP_MUL  = 4'b1010;
    localparam logic [OPW-1:0] OP_SWAP = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [OPW-1:0]    op_q, op_d;
    logic [DW-1:0]     opnd_q, opnd_d;
    logic [DW-1:0]     acc_q, acc_d;
    logic [DW-1:0]     ph_q, ph_d;
    logic [DW-1:0]     p_q, p_d;
    logic [DW-1:0]     q_q, q_d;
    logic [DW-1:0]     m_q, m_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              c_q, c_d, v_q, v_d, z_q, z_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic [DW-1:0]     alu_a_q, alu_a_d;
    logic [DW-1:0]     alu_b_q, alu_b_d;
    logic [CW-1:0]     alu_ctrl_q, alu_ctrl_d;

    // State register and datapath flops
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            ph_q       <= '0;
            p_q        <= '0;
            q_q        <= '0;
            m_q        <= '0;
            cnt_q      <= '0;
            c_q        <= 1'b0;
            v_q        <= 1'b0;
            z_q        <= 1'b1;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            ph_q       <= ph_d;
            p_q        <= p_d;
            q_q        <= q_d;
            m_q        <= m_d;
            cnt_q      <= cnt_d;
            c_q        <= c_d;
            v_q        <= v_d;
            z_q        <= z_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
        end
    end

    // Next-state, writeback and next-cycle ALU drive
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        ph_d    = ph_q;
        p_d     = p_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        v_d     = v_q;
        z_d     = z_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (op_valid_in) begin
                    op_d   = opcode_in;
                    opnd_d = operand_in;
                    if (opcode_in == OP_MUL) begin
                        state_d = ST_MUL;
                        cnt_d   = CNT_W'(MUL_ITER);
                        q_d     = acc_q;
                        m_d     = operand_in;
                        p_d     = '0;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (!op_q[OPW-1]) begin
                    acc_d = alu_sum_in;
                    c_d   = alu_carry_in;
                    v_d   = alu_overflow_in;
                    z_d   = alu_zero_in;
                end else if (op_q == OP_LDA) begin
                    acc_d = opnd_q;
                    z_d   = (opnd_q == '0);
                end else if (op_q == OP_CLR) begin
                    acc_d = '0;
                    ph_d  = '0;
                    c_d   = 1'b0;
                    v_d   = 1'b0;
                    z_d   = 1'b1;
                end else if (op_q == OP_SWAP) begin
                    acc_d = ph_q;
                    ph_d  = acc_q;
                    z_d   = (ph_q == '0);
                end
            end
            ST_MUL: begin
                // Shift the ALU sum (with carry) into P and the multiplier out of Q
                {p_d, q_d} = {alu_carry_in, alu_sum_in, q_q[DW-1:1]};
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    ph_d    = p_d;
                    acc_d   = q_d;
                    z_d     = ({p_d, q_d} == '0);
                    c_d     = (p_d != '0);
                    v_d     = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);

        // ALU inputs are registered, so they are derived from next-cycle state
        alu_a_d    = acc_d;
        alu_b_d    = '0;
        alu_ctrl_d = '0;
        if (state_d == ST_MUL) begin
            alu_a_d    = p_d;
            alu_b_d    = q_d[0] ? m_d : '0;
            alu_ctrl_d = ALU_ADD;
        end else if (state_d == ST_EXEC && !op_d[OPW-1]) begin
            alu_a_d    = acc_d;
            alu_b_d    = opnd_d;
            alu_ctrl_d = op_d[CW-1:0];
        end
    end

    assign op_ready_out      = ready_q;
    assign alu_a_out         = alu_a_q;
    assign alu_b_out         = alu_b_q;
    assign alu_ctrl_out      = alu_ctrl_q;
    assign acc_out           = acc_q;
    assign ph_out            = ph_q;
    assign carry_flag_out    = c_q;
    assign overflow_flag_out = v_q;
    assign zero_flag_out     = z_q;
    assign done_out          = done_q;

endmodule

// File: doc/acc_exec_unit.md
# acc_exec_unit

Execute-stage sequencer for the accumulator processor. It sits directly upstream and downstream of the 8-bit ALU: it drives `alu_a_out`, `alu_b_out` and `alu_ctrl_out` from the accumulator and an operand. It then captures the ALU sum and flags back into the accumulator and the flag register. It adds a multi-cycle 8x8 unsigned multiply built from repeated ALU adds, and a valid/ready handshake toward the decode stage.

## Interface
- `ALU_ADD`, default 3'b010: ALU control code that performs A+B with carry-in 0. Used for the MUL iterations.
- `MUL_ITER`, default 8: number of multiply iterations, equal to the data width.

Ports:
- `clk_in` input 1: clock. All state changes on the rising edge.
- `rst_n_in` input 1: reset. One clock; reset is asynchronous and active-low.
- `op_valid_in` input 1: opcode/operand offered.
- `op_ready_out` output 1: unit can accept an op this cycle.
- `opcode_in` input 4: operation; encoding below.
- `operand_in` input 8: B operand / load value / multiplicand.
- `alu_a_out` output 8: drives ALU `a_in`.
- `alu_b_out` output 8: drives ALU `b_in`.
- `alu_ctrl_out` output 3: drives ALU `control_in`.
- `alu_sum_in` input 8: ALU `sum_out`.
- `alu_carry_in` input 1: ALU `carry_out`.
- `alu_overflow_in` input 1: ALU `overflow_out`.
- `alu_zero_in` input 1: ALU `zero_out`.
- `acc_out` output 8: accumulator ACC.
- `ph_out` output 8: product-high register PH.
- `carry_flag_out` output 1: flag C.
- `overflow_flag_out` output 1: flag V.
- `zero_flag_out` output 1: flag Z.
- `done_out` output 1: one-cycle pulse when an op's writeback is visible.

## Operation
- Opcodes:
  - 0ccc ALU op: A=ACC, B=operand, ctrl=ccc passed unchanged. ACC←alu_sum; C,V,Z←ALU flags.
  - 1000 LDA: ACC←operand; Z←(operand==0); C,V unchanged.
  - 1001 CLR: ACC←0, PH←0, C←0, V←0, Z←1.
  - 1010 MUL: {PH,ACC}←ACC×operand, unsigned. Z←(16-bit product==0); C←(PH!=0); V←0.
  - 1011 SWAP: ACC↔PH; Z←(new ACC==0); C,V unchanged.
  - 11xx NOP: no state change; `done_out` still pulses.
- Registered inputs: opcode and operand are latched on acceptance (`op_valid_in && op_ready_out`) into OP_R and OPND_R. Later changes to the inputs are ignored.
- FSM states: IDLE, EXEC, MUL.
  - IDLE: `op_ready_out`=1. On accept, go to MUL if opcode is 1010, else to EXEC.
  - EXEC: lasts one cycle. Writeback occurs on the exiting edge, then IDLE.
  - MUL: lasts `MUL_ITER` cycles, tracked by a 4-bit counter that counts down from 8. Final writeback occurs on the exiting edge, then IDLE.
- MUL datapath:
  - Setup on accept: Q←ACC, M←operand, P←0.
  - Each MUL cycle drives `alu_a_out`=P and `alu_ctrl_out`=`ALU_ADD`. `alu_b_out`=M if Q[0], else 0.
  - At the edge: {P,Q}←{alu_carry_in, alu_sum_in, Q[7:1]}.
  - After 8 cycles: PH←P, ACC←Q.
- ALU drive outside MUL:
  - EXEC with an ALU op: drive A/B/ctrl as above.
  - All other states and ops: `alu_a_out`=ACC, `alu_b_out`=0, `alu_ctrl_out`=0. These values are don't-care to consumers.
- Flags from the ALU are sampled only at ALU-op writeback. At any other time, ALU outputs never change flags.

## Timing
- Reset values: ACC=0, PH=0, C=0, V=0, Z=1, `done_out`=0, `op_ready_out`=1, state IDLE, counter 0, `alu_*_out`=0.
- Single-cycle ops:
  - Accept at edge k; EXEC during cycle k..k+1.
  - Results and `done_out`=1 are visible after edge k+1.
  - `op_ready_out`=1 in the same cycle as `done_out`.
  - Maximum throughput is one op per 2 cycles.
- MUL:
  - Accept at edge k; iterations on edges k+1..k+8.
  - {PH,ACC} and `done_out` are visible after edge k+8.
  - `op_ready_out`=0 for the 8 cycles between accept and done.
- `op_valid_in` while `op_ready_out`=0: ignored. The op is not queued. The producer holds valid until ready.
- `done_out` is registered and high for exactly one cycle per accepted op.
- Reset asserted mid-op: immediate abort, all registers return to reset values, no `done_out`.
- Intermediate ACC/PH values are never visible during MUL. ACC and PH hold their pre-op values until the final edge.

## Test plan
- Reset, then check outputs: ACC=0x00, PH=0x00, Z=1, C=0, V=0, `op_ready_out`=1, `done_out`=0.
- LDA 0x7F, then ALU op ctrl=`ALU_ADD` with operand 0x01. Required: ACC=0x80, V=1, C=0, Z=0, `done_out` exactly 2 cycles after the accept edge.
- LDA 0x0F, then MUL 0x11. Required: ACC=0xFF, PH=0x00, C=0, Z=0, `done_out` 9 cycles after the accept edge, `op_ready_out` low for 8 cycles.
- LDA 0xFF, then MUL 0xFF. Required: PH=0xFE, ACC=0x01, C=1, V=0. Follow with SWAP: ACC=0xFE, PH=0x01.
- Hold `op_valid_in` with CLR throughout a MUL. Required: CLR accepted only in the cycle `done_out` pulses; afterwards ACC=0, PH=0, Z=1.
- Assert `rst_n_in` at iteration 4 of MUL 0x03×0x05. Required: no `done_out`; ACC=0, PH=0, Z=1; a subsequent LDA 0x42 completes normally.
